// File: rtl/mips_pkg.sv
// Shared definitions for the processor's arbitration blocks: output-stage
// state names, arbitration mode encodings and a clog2 helper.
package mips_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  // Index width for n items, never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_mux_n_if.sv
// Handshake bundle between the requesting channels, the arbitrated mux and
// its downstream consumer.
interface arb_mux_n_if import mips_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int N_CH  = 4
) ();
  localparam int CH_W = clog2_min1(N_CH);

  logic [N_CH-1:0]       i_valid;
  logic [N_CH*WIDTH-1:0] i_data;
  logic [N_CH-1:0]       o_ready;
  logic                  o_valid;
  logic [WIDTH-1:0]      o_data;
  logic [CH_W-1:0]       o_ch;
  logic                  i_ready;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_ch
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_ch
  );
endinterface

// File: rtl/rr_prio_pick.sv
// Rotating priority encoder: grants the first request at or above ptr,
// wrapping past the top channel back to channel 0.
module rr_prio_pick import mips_pkg::*; #(
  parameter  int N_CH = 4,
  localparam int CH_W = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [N_CH-1:0] gnt,
  output logic [CH_W-1:0] gnt_idx,
  output logic            any
);

  logic [2*N_CH-1:0] req2;
  logic [2*N_CH-1:0] masked;
  logic              hit;
  int                pos;

  // The upper copy of the request vector stands in for the wrap-around, so
  // a plain lowest-set-bit scan above ptr covers the rotation.
  always_comb begin
    req2   = {req, req};
    masked = '0;
    hit    = 1'b0;
    pos    = 0;
    for (int i = 0; i < 2*N_CH; i++) begin
      masked[i] = req2[i] && (i >= int'(ptr));
    end
    for (int i = 2*N_CH-1; i >= 0; i--) begin
      if (masked[i]) begin
        hit = 1'b1;
        pos = i;
      end
    end
    gnt_idx = (pos >= N_CH) ? CH_W'(pos - N_CH) : CH_W'(pos);
    gnt     = '0;
    if (hit) gnt[gnt_idx] = 1'b1;
    any     = hit;
  end

endmodule

// File: rtl/arb_mux_n.sv
// N-input arbitrated multiplexer: picks one requesting channel per cycle
// (round-robin or fixed priority) and registers its word with the source index.
module arb_mux_n import mips_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int N_CH    = 4,
  parameter int RR_MODE = ARB_RR
) (
  input  logic        i_clk,
  input  logic        i_rst,
  arb_mux_n_if.slave  bus
);

  localparam int CH_W = clog2_min1(N_CH);

  out_state_t       state_q;
  out_state_t       state_d;
  logic [CH_W-1:0]  ptr_q;
  logic [CH_W-1:0]  gnt_idx;
  logic [N_CH-1:0]  gnt;
  logic             any;
  logic             can_load;
  logic             xfer;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] sel_data;
  logic [CH_W-1:0]  ch_q;

  rr_prio_pick #(.N_CH(N_CH)) u_pick (
    .req     (bus.i_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Reset blocks acceptance so a held request is never lost to a wiped register.
  assign can_load    = (state_q == ST_EMPTY) || bus.i_ready;
  assign xfer        = any && can_load && !i_rst;
  assign bus.o_ready = xfer ? gnt : '0;

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt_idx == CH_W'(k)) sel_data = bus.i_data[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (xfer)                                     state_d = ST_FULL;
    else if (state_q == ST_FULL && bus.i_ready)   state_d = ST_EMPTY;
  end

  always_comb begin
    bus.o_valid = (state_q == ST_FULL);
    bus.o_data  = data_q;
    bus.o_ch    = ch_q;
  end

  // In fixed-priority mode the pointer never leaves 0, so channel 0 always
  // heads the scan.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_q <= '0;
      ch_q   <= '0;
      ptr_q  <= '0;
    end else if (xfer) begin
      data_q <= sel_data;
      ch_q   <= gnt_idx;
      if (RR_MODE == ARB_RR) begin
        ptr_q <= (gnt_idx == CH_W'(N_CH-1)) ? '0 : gnt_idx + CH_W'(1);
      end
    end
  end

endmodule

// File: doc/arb_mux_n.md
# arb_mux_n

Parametrised N-input arbitrated multiplexer with a registered output and valid/ready handshakes. It generalises the processor's combinational select muxes to shared-resource ports, such as the single memory port contended by instruction fetch, data access and debug. The requester is no longer chosen by an external control code. The block arbitrates in round-robin or fixed-priority mode, registers the winning word and reports which channel it came from.

## Interface
Parameters:
- WIDTH, 32, data width per channel.
- N_CH, 4, number of input channels; legal range 2..16.
- RR_MODE, 1; 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
- CH_W, derived, clog2(N_CH), minimum 1; not overridable.

Ports:
- i_clk  in  1  single clock; all state updates on its rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_valid  in  N_CH  per-channel request; bit k belongs to channel k.
- i_data  in  N_CH*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- o_ready  out  N_CH  per-channel accept, one-hot or zero.
- o_valid  out  1  output register holds a word.
- o_data  out  WIDTH  registered winning word.
- o_ch  out  CH_W  index of the channel that supplied o_data.
- i_ready  in  1  downstream accept.

## Operation
- Output stage is a single register with two states:
  - EMPTY (o_valid=0).
  - FULL (o_valid=1).
- can_load = EMPTY, or (FULL and i_ready).
- Arbitration, combinational each cycle:
  - The winner is the first asserted i_valid bit, scanning upward from pointer ptr and wrapping from N_CH-1 to 0.
  - o_ready[winner] = can_load; all other o_ready bits = 0.
  - With no i_valid asserted, o_ready = 0.
- Transfer on channel k happens when i_valid[k] and o_ready[k]. On transfer, the register loads i_data[k]; o_ch loads k; the state becomes FULL.
- Drain happens when FULL and i_ready:
  - With no simultaneous transfer, the state becomes EMPTY.
  - With a simultaneous transfer, the state stays FULL with the new word. This is back-to-back operation with no bubble.
- Pointer update:
  - RR_MODE=1: after a transfer on channel k, ptr becomes (k+1) mod N_CH. ptr is unchanged in cycles with no transfer.
  - RR_MODE=0: ptr stays 0 permanently.
- Stability rule: while FULL and i_ready=0, o_data and o_ch hold constant.
- Upstream obligation: i_data[k] is held stable while i_valid[k]=1 and the channel is not yet accepted. The block does not check this.
- Reset: i_rst=1 forces EMPTY, o_valid=0, o_data=0, o_ch=0, ptr=0 on the next edge.
  - Reset overrides any same-cycle transfer or drain.
  - A word held when reset arrives is discarded.
  - While i_rst=1, o_ready=0.

## Timing
- Latency: 1 cycle from accept edge to o_valid=1 with the word on o_data.
- Throughput: one word per cycle when i_ready is held high.
- o_ready depends combinationally on i_valid, i_ready and state. The path is i_ready to o_ready; there is no path from i_valid to o_valid within a cycle.
- Fairness (RR_MODE=1): with all N_CH channels continuously requesting and i_ready=1, each channel is granted exactly once in every N_CH consecutive transfers.
- Starvation bound: a channel that is continuously requesting waits at most N_CH-1 transfers.
- Wrap-around: grant to channel N_CH-1 sets ptr=0.
- First cycle after reset: channel 0 has highest priority.

## Structure
- Shared package mips_pkg holds:
  - the clog2 helper used for CH_W;
  - the named state constants ST_EMPTY/ST_FULL (1-bit encoding);
  - the RR_MODE encodings ARB_RR=1 and ARB_FIXED=0.
- Sub-module rr_prio_pick: combinational rotating priority encoder.
  - Inputs: req[N_CH], ptr[CH_W].
  - Outputs: gnt one-hot, gnt_idx, any.
  - Implementation: double-width request vector, masked scan, fold back. It is reused by future arbiters.
- Top-level contents: output register, state bit, ptr register, o_ready gating, data selection by gnt_idx.

## Test plan
- Reset then idle: i_rst=1 for 2 cycles, then i_valid=0 -> o_valid=0, o_data=0, o_ch=0, o_ready=0 throughout.
- Single channel, N_CH=4, WIDTH=32:
  - Stimulus: i_valid=4'b0100, channel 2 data 32'hDEAD_BEEF, i_ready=1.
  - Response: o_ready=4'b0100; the following cycle o_valid=1, o_data=32'hDEAD_BEEF, o_ch=2.
- Round-robin fairness:
  - Stimulus: i_valid=4'b1111 for 8 cycles, i_ready=1, RR_MODE=1.
  - Response: o_ch sequence 0,1,2,3,0,1,2,3, with no gaps in o_valid.
- Fixed priority:
  - Stimulus: RR_MODE=0, i_valid=4'b1010 held, i_ready=1.
  - Response: every grant goes to channel 1; channel 3 is never granted while channel 1 requests.
- Backpressure:
  - Stimulus: load word A from channel 0, then i_ready=0 for 3 cycles with i_valid=4'b0010.
  - Response: o_data=A and o_ch=0 stable; o_ready=0. When i_ready=1, channel 1 is accepted on the same edge A drains, and the next cycle shows channel 1's word.
- Reset mid-operation:
  - Stimulus: FULL with ptr=3, then i_rst=1 for one cycle while i_valid=4'b1111.
  - Response: o_valid=0 after the edge, with no transfer. The first grant after release goes to channel 0.
